// File: rtl/mmid_dbus_ctrl.sv
// MMID-stage data-bus controller: issues req/ack bus accesses, stalls the pipe, aligns load data.
// Optional DBUS_TIMEOUT_EN adds a no-ack watchdog that retires the access with bus-error code 7.
module mmid_dbus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_clr,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  exc_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic        acc_done,
  output logic [31:0] ldata_out,
  output logic [4:0]  exc_out
);
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            req_nxt, we_nxt;
  logic [DW-1:0]   addr_nxt, wdata_nxt, wdata_c, shifted;
  logic [3:0]      be_nxt, be_c;
  logic [1:0]      lo_q, lo_nxt;
  logic [2:0]      op_q, op_nxt;
  logic            mem, misal, start, tmo, bus_err;

  assign mem   = load_in | store_in;
  assign start = mem & (exc_in == '0) & !misal & !int_clr;

  // Size decode from op[1:0]: byte, half, everything else word.
  always_comb begin
    misal   = 1'b0;
    be_c    = 4'b1111;
    wdata_c = wdata_in;
    case (op_in[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_in[1:0];
        wdata_c = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        misal   = addr_in[0];
        be_c    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_in[15:0]}};
      end
      default: misal = |addr_in[1:0];
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic          clr_cnt;

  assign clr_cnt = ((state == IDLE) && start) || ((state == WAIT) && (state_nxt == DRAIN));
  assign tmo     = (state != IDLE) && !dbus_ack && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr_cnt)
      cnt <= '0;
    else if ((state != IDLE) && !dbus_ack)
      cnt <= cnt + CW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state, bus capture and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_nxt   = dbus_req;
    we_nxt    = dbus_we;
    addr_nxt  = dbus_addr;
    be_nxt    = dbus_be;
    wdata_nxt = dbus_wdata;
    lo_nxt    = lo_q;
    op_nxt    = op_q;
    stall     = 1'b0;
    acc_done  = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          we_nxt    = store_in & !load_in;
          addr_nxt  = {addr_in[31:2], 2'b00};
          be_nxt    = be_c;
          wdata_nxt = wdata_c;
          lo_nxt    = addr_in[1:0];
          op_nxt    = op_in;
          stall     = 1'b1;
        end
      end
      WAIT: begin
        if (dbus_ack || tmo) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          acc_done  = 1'b1;
          bus_err   = !dbus_ack;
        end else begin
          stall = 1'b1;
          if (int_clr) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall = !tmo;
        if (dbus_ack || tmo) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      lo_q       <= '0;
      op_q       <= '0;
    end else begin
      state      <= state_nxt;
      dbus_req   <= req_nxt;
      dbus_we    <= we_nxt;
      dbus_addr  <= addr_nxt;
      dbus_be    <= be_nxt;
      dbus_wdata <= wdata_nxt;
      lo_q       <= lo_nxt;
      op_q       <= op_nxt;
    end
  end

  // Parameter range guard; the watchdog compare is only meaningful for 1..255.
  always_ff @(posedge clk) begin
    assert (TIMEOUT >= 1 && TIMEOUT <= 255);
  end

  // Load alignment uses the captured low address bits and op.
  always_comb begin
    shifted = dbus_rdata >> {lo_q, 3'b000};
    case (op_q[1:0])
      2'b00:   ldata_out = {{24{shifted[7] & ~op_q[2]}}, shifted[7:0]};
      2'b01:   ldata_out = {{16{shifted[15] & ~op_q[2]}}, shifted[15:0]};
      default: ldata_out = dbus_rdata;
    endcase
  end

  always_comb begin
    exc_out = '0;
    if (exc_in != '0)
      exc_out = exc_in;
    else if (mem && misal)
      exc_out = load_in ? EW'(4) : EW'(5);
    else if (bus_err)
      exc_out = EW'(7);
  end

endmodule

// File: tb/tb_mmid_dbus_ctrl.sv
// Randomized self-checking bench for mmid_dbus_ctrl against a transaction-level model.
module tb_mmid_dbus_ctrl;
  logic        clk = 1'b0;
  logic        reset, int_clr, load_in, store_in;
  logic [2:0]  op_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  exc_in;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, ldata_out;
  logic [3:0]  dbus_be;
  logic        stall, acc_done;
  logic [4:0]  exc_out;

  int total = 0;
  int bad   = 0;

  logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

  mmid_dbus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .int_clr(int_clr), .load_in(load_in), .store_in(store_in),
    .op_in(op_in), .addr_in(addr_in), .wdata_in(wdata_in), .exc_in(exc_in),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .stall(stall), .acc_done(acc_done), .ldata_out(ldata_out), .exc_out(exc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = nbytes(op);
    v = rd >> (8 * int'(lo));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!op[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] op, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    n = nbytes(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [1:0] lo);
    int n;
    n = nbytes(op);
    return 4'(((1 << n) - 1) << int'(lo));
  endfunction

  // One instruction through MMID: pass-through or a full bus access with waits/flush.
  task automatic run_instr(input logic ld, input logic st, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] exc,
                           input logic clr_idle, input int waits, input int flush,
                           input logic clr_ack, input logic [31:0] rd);
    logic misal, flushed;
    misal   = (int'(addr[1:0]) % nbytes(op)) != 0;
    flushed = (flush >= 0) && (flush < waits);
    @(negedge clk);
    load_in = ld; store_in = st; op_in = op; addr_in = addr; wdata_in = wd;
    exc_in = exc; int_clr = clr_idle; dbus_ack = 1'b0;
    #1;
    if (!(ld | st) || exc != 0 || misal || clr_idle) begin
      check("pass_stall", 32'(stall), 32'd0);
      check("pass_done", 32'(acc_done), 32'd0);
      check("pass_exc", 32'(exc_out),
            (exc != 0) ? 32'(exc) : ((ld | st) && misal) ? (ld ? 32'd4 : 32'd5) : 32'd0);
      @(posedge clk); #1;
      check("pass_req", 32'(dbus_req), 32'd0);
    end else begin
      check("issue_req", 32'(dbus_req), 32'd0);
      check("issue_stall", 32'(stall), 32'd1);
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        check("wait_req", 32'(dbus_req), 32'd1);
        check("wait_addr", dbus_addr, {addr[31:2], 2'b00});
        check("wait_we", 32'(dbus_we), 32'(st));
        if (st) begin
          check("wait_be", 32'(dbus_be), 32'(exp_be(op, addr[1:0])));
          check("wait_wdata", dbus_wdata, exp_wd(op, wd));
        end
        if (i == waits) begin
          dbus_ack = 1'b1; dbus_rdata = rd;
          int_clr = flushed ? 1'b0 : clr_ack;
          #1;
          check("ack_done", 32'(acc_done), flushed ? 32'd0 : 32'd1);
          check("ack_stall", 32'(stall), flushed ? 32'd1 : 32'd0);
          if (!flushed) begin
            check("ack_exc", 32'(exc_out), 32'd0);
            if (ld) check("ack_ldata", ldata_out, exp_ld(op, addr[1:0], rd));
          end
        end else begin
          int_clr = (i == flush);
          dbus_rdata = $urandom;
          #1;
          check("wait_stall", 32'(stall), 32'd1);
          check("wait_done", 32'(acc_done), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic ld, st, ci, ca;
    logic [2:0] op;
    logic [31:0] a;
    logic [4:0] ex;
    int k, w, f;
    reset = 1'b1; int_clr = 0; load_in = 0; store_in = 0; op_in = 0;
    addr_in = 0; wdata_in = 0; exc_in = 0; dbus_ack = 0; dbus_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_we", 32'(dbus_we), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_be", 32'(dbus_be), 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(acc_done), 32'd0);
    reset = 1'b0;

    run_instr(1, 0, 3'b000, 32'h0000_1003, 0, 0, 0, 2, -1, 0, 32'h80FF_FF12);
    run_instr(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 0, -1, 0, 0);
    run_instr(1, 0, 3'b010, 32'h0000_3001, 0, 0, 0, 0, -1, 0, 0);
    run_instr(1, 0, 3'b010, 32'h0000_3001, 0, 5'd10, 0, 0, -1, 0, 0);
    run_instr(0, 1, 3'b001, 32'h0000_2001, 0, 0, 0, 0, -1, 0, 0);
    run_instr(1, 0, 3'b101, 32'h0000_4002, 0, 0, 0, 3, 0, 0, 32'hDEAD_BEEF);
    run_instr(0, 1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 0, 0, 0, -1, 0, 0);
    run_instr(1, 0, 3'b010, 32'h0000_5008, 0, 0, 0, 0, -1, 0, 32'h0BAD_CAFE);
    run_instr(1, 0, 3'b010, 32'h0000_6000, 0, 0, 1, 0, -1, 0, 0);
    run_instr(1, 0, 3'b100, 32'h0000_6001, 0, 0, 0, 1, -1, 1, 32'h0000_9A00);

    // Synchronous reset while an access is outstanding.
    @(negedge clk);
    load_in = 1; store_in = 0; op_in = 3'b010; addr_in = 32'h7000; exc_in = 0;
    int_clr = 0; dbus_ack = 0;
    @(negedge clk);
    reset = 1'b1; load_in = 0;
    @(negedge clk); #1;
    check("midrst_req", 32'(dbus_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

`ifdef DBUS_TIMEOUT_EN
    @(negedge clk);
    load_in = 1; store_in = 0; op_in = 3'b010; addr_in = 32'h8000; exc_in = 0;
    int_clr = 0; dbus_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("tmo_req", 32'(dbus_req), 32'd1);
      check("tmo_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
      check("tmo_done", 32'(acc_done), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check("tmo_exc", 32'(exc_out), 32'd7);
    end
    @(negedge clk);
    load_in = 0; #1;
    check("tmo_req_drop", 32'(dbus_req), 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 9));
      ld = (k < 4);
      st = (k >= 4) && (k < 8);
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      ex = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ci = ($urandom_range(0, 9) == 0);
      w  = int'($urandom_range(0, 3));
      f  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      ca = (f < 0) && ($urandom_range(0, 4) == 0);
      run_instr(ld, st, op, a, $urandom, ex, ci, w, f, ca, $urandom);
    end

    @(negedge clk);
    load_in = 0; store_in = 0; int_clr = 0; dbus_ack = 0;
    @(negedge clk); #1;
    check("end_stall", 32'(stall), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
